// File: rtl/sbn_pkg.sv
// Shared SBN definitions: default widths and the requester-ID encoding
// used by the data-memory arbiter's owner tag and round-robin state.
package sbn_pkg;

    localparam int FWIDTH = 8;
    localparam int DWIDTH = 32;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

endpackage

// File: rtl/sbn_rr2.sv
// Two-way round-robin pick with its "last granted" register; reusable by
// any two-requester SBN arbiter.
module sbn_rr2
    import sbn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_core,
    input  logic i_req_host,
    output logic o_gnt_core,
    output logic o_gnt_host
);

    req_id_t r_last;
    logic    w_gnt_core;
    logic    w_gnt_host;

    // On a conflict the side that did not win last time goes first.
    assign w_gnt_core = i_req_core & (~i_req_host | (r_last == REQ_HOST));
    assign w_gnt_host = i_req_host & ~w_gnt_core;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_HOST;
        end else if (w_gnt_core) begin
            r_last <= REQ_CORE;
        end else if (w_gnt_host) begin
            r_last <= REQ_HOST;
        end
    end

    assign o_gnt_core = w_gnt_core;
    assign o_gnt_host = w_gnt_host;

endmodule

// File: rtl/sbn_dmem_arb.sv
// Core/host arbiter for the single-port SBN data memory: one access per
// cycle, read-data routing by owner tag, core freeze handshake, contention count.
module sbn_dmem_arb
    import sbn_pkg::*;
#(
    parameter int FWIDTH = sbn_pkg::FWIDTH,
    parameter int DWIDTH = sbn_pkg::DWIDTH,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [FWIDTH-1:0] core_addr,
    input  logic [DWIDTH-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DWIDTH-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [FWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DWIDTH-1:0] host_rdata,

    input  logic              freeze,
    output logic              freeze_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [FWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,

    output logic [CWIDTH-1:0] contention
);

    logic              w_core_elig;
    logic              w_host_elig;
    logic              w_core_gnt;
    logic              w_host_gnt;

    logic              r_rd_pend;
    req_id_t           r_rd_owner;
    logic              r_freeze_ack;
    logic [CWIDTH-1:0] r_contention;

    assign w_core_elig = core_req & ~freeze;
    assign w_host_elig = host_req;

    // Requests are masked by rst_n so nothing is granted while reset is held.
    sbn_rr2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_core (w_core_elig & rst_n),
        .i_req_host (w_host_elig & rst_n),
        .o_gnt_core (w_core_gnt),
        .o_gnt_host (w_host_gnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_core_gnt) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= REQ_CORE;
            r_freeze_ack <= 1'b0;
            r_contention <= '0;
        end else begin
            r_rd_pend    <= mem_en & ~mem_we;
            r_rd_owner   <= w_host_gnt ? REQ_HOST : REQ_CORE;
            r_freeze_ack <= freeze;
            if (w_core_elig && w_host_elig && (r_contention != {CWIDTH{1'b1}})) begin
                r_contention <= r_contention + 1'b1;
            end
        end
    end

    assign core_gnt    = w_core_gnt;
    assign host_gnt    = w_host_gnt;
    assign core_rvalid = r_rd_pend & (r_rd_owner == REQ_CORE);
    assign host_rvalid = r_rd_pend & (r_rd_owner == REQ_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign freeze_ack  = r_freeze_ack;
    assign contention  = r_contention;

endmodule

// File: doc/sbn_dmem_arb.md
# sbn_dmem_arb

Two-port arbiter that shares the single-port SBN data memory between the SBN core (operand fetch/result store) and a host port (program/data loader, debugger). Grants at most one access per cycle with round-robin fairness, routes synchronous read data back to the owning requester, supports a freeze handshake that quiesces the core side, and counts contention cycles. Sits between the SBN core/host logic and the `dmem` array.

## Interface
- `FWIDTH`, 8, address width; memory depth is 2^FWIDTH words
- `DWIDTH`, 32, data word width
- `CWIDTH`, 16, contention counter width

- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `core_req` / `host_req` in 1: access request; held until granted
- `core_we` / `host_we` in 1: 1 = write, 0 = read
- `core_addr` / `host_addr` in FWIDTH: word address
- `core_wdata` / `host_wdata` in DWIDTH: write data
- `core_gnt` / `host_gnt` out 1: access accepted this cycle (combinational)
- `core_rvalid` / `host_rvalid` out 1: read data valid this cycle
- `core_rdata` / `host_rdata` out DWIDTH: read data
- `freeze` in 1: block all new core grants
- `freeze_ack` out 1: core side quiesced, no core read in flight
- `mem_en`, `mem_we` out 1; `mem_addr` out FWIDTH; `mem_wdata` out DWIDTH: memory command
- `mem_rdata` in DWIDTH: memory read data, valid one cycle after `mem_en & ~mem_we`
- `contention` out CWIDTH: saturating count of cycles with both requests eligible

## Operation
- Eligible: `core_elig = core_req & ~freeze`, `host_elig = host_req`.
- One eligible requester: it is granted. Both eligible: grant the requester **not** granted most recently (`last` register), then update `last`.
- `last` updates only on a grant; reset value = host, so core wins the first conflict.
- Granted requester's `we/addr/wdata` drive `mem_*`; `mem_en = core_gnt | host_gnt`. No grant: `mem_en=0`, `mem_we=0`, `mem_addr`/`mem_wdata` = 0.
- Read grant sets a one-cycle owner tag; next cycle `mem_rdata` is routed to the owner's `rdata` with its `rvalid=1`. Non-owner `rdata` = 0. Writes produce no `rvalid`.
- `freeze_ack` register: next = `freeze`. Because core cannot be granted while `freeze=1`, any core read granted before `freeze` rose returns no later than the cycle `freeze_ack` rises.
- `contention` increments when `core_elig & host_elig`, saturates at 2^CWIDTH−1 (no wrap).
- Requester changing `addr/we/wdata` while `req=1` and ungranted is legal; the values present in the grant cycle are used.

## Timing
- Grant latency: 0 cycles (same cycle as eligible `req`); throughput: one access per cycle.
- Read latency: `rvalid` exactly 1 cycle after the grant; back-to-back reads return back-to-back.
- Write takes effect at the grant-cycle edge; a read granted the following cycle by either port returns the new value.
- Reset (async, any time): `last`=host, owner tag cleared, all `rvalid`=0, `freeze_ack`=0, `contention`=0; while `rst_n=0` both `gnt`=0 and `mem_en`=0. An in-flight read at reset assertion is dropped (no `rvalid` after release).
- Simultaneous `freeze` rise and core request: core not granted that cycle.
- `freeze` falls: core eligible same cycle; `freeze_ack` falls next cycle.

## Structure
- Shared package `sbn_pkg`: `FWIDTH`/`DWIDTH` defaults and requester-ID encoding (`REQ_CORE=0`, `REQ_HOST=1`) used by the owner tag and `last`.
- No sub-module needed; one optional `sbn_rr2` (2-way round-robin pick + `last` register) if reused by a future imem loader arbiter.

## Test plan
- Reset release, only core reads addr 0x05 (mem holds 0x0000_0007) → `core_gnt` same cycle, `core_rvalid=1`, `core_rdata=0x0000_0007` next cycle; host outputs stay 0.
- Both request continuously for 6 cycles → grants alternate core, host, core, host, core, host; `contention`=6.
- Host writes 0x0000_00AA to 0x10, core reads 0x10 next cycle → `core_rdata=0x0000_00AA`.
- Core read granted at cycle t, `freeze` raised at t+1 with `core_req` held → `core_rvalid` at t+1, no `core_gnt` during freeze, `freeze_ack=1` at t+2; host grants unaffected.
- `CWIDTH=4`, both requesting 20 cycles → `contention` stops at 15.
- Assert `rst_n=0` the cycle after a host read grant → no `host_rvalid`, `contention=0`, next conflict after release grants core first.
